// File: rtl/phase_freq_detector.sv
// rtl/phase_freq_detector.sv - sampled tri-state phase/frequency detector with lock tracking

module pfd_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    // Shift the asynchronous input through the synchronizer and keep one history bit
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and history flops, free-running regardless of enable
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

module phase_freq_detector #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_CNT    = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             ref_in,
    input  logic             fb_in,
    output logic             up,
    output logic             dn,
    output logic [CNT_W-1:0] phase_err,
    output logic             err_valid,
    output logic             lock
);

    localparam int               LK_W    = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] TOL_V   = CNT_W'(LOCK_TOL);
    localparam logic [LK_W-1:0]  LK_MAX  = LK_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REF_LEAD = 2'd1,
        ST_FB_LEAD  = 2'd2
    } state_t;

    logic             ref_rise;
    logic             fb_rise;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             up_q,        up_d;
    logic             dn_q,        dn_d;
    logic [CNT_W-1:0] phase_err_q, phase_err_d;
    logic             err_valid_q, err_valid_d;
    logic [LK_W-1:0]  lk_q,        lk_d;
    logic             lock_q,      lock_d;

    logic             meas_valid;
    logic             meas_neg;
    logic [CNT_W-1:0] meas_mag;
    logic [CNT_W-1:0] cnt_inc;

    pfd_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ref_edge (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .din    (ref_in),
        .rise   (ref_rise)
    );

    pfd_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_fb_edge (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .din    (fb_in),
        .rise   (fb_rise)
    );

    // Next-state logic: open a measurement on the leading edge, close it on the lagging edge,
    // and fold each closed measurement into the lock run counter
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_err_d = phase_err_q;
        err_valid_d = 1'b0;
        lk_d        = lk_q;
        lock_d      = lock_q;
        meas_valid  = 1'b0;
        meas_neg    = 1'b0;
        meas_mag    = '0;
        // The counter pins at the largest positive error so a missing edge never wraps
        cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            lk_d    = '0;
            lock_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ref_rise && fb_rise) begin
                        meas_valid = 1'b1;
                    end else if (ref_rise) begin
                        state_d = ST_REF_LEAD;
                        cnt_d   = CNT_W'(1);
                    end else if (fb_rise) begin
                        state_d = ST_FB_LEAD;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_REF_LEAD: begin
                    if (fb_rise) begin
                        meas_valid = 1'b1;
                        meas_mag   = cnt_q;
                        // A coincident new ref edge starts the next measurement at once
                        if (ref_rise) begin
                            cnt_d = CNT_W'(1);
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        // Extra ref edges are a frequency error: keep counting
                        cnt_d = cnt_inc;
                    end
                end
                ST_FB_LEAD: begin
                    if (ref_rise) begin
                        meas_valid = 1'b1;
                        meas_neg   = 1'b1;
                        meas_mag   = cnt_q;
                        if (fb_rise) begin
                            cnt_d = CNT_W'(1);
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (meas_valid) begin
            err_valid_d = 1'b1;
            phase_err_d = meas_neg ? (CNT_W'(0) - meas_mag) : meas_mag;
            if (meas_mag <= TOL_V) begin
                lk_d = (lk_q == LK_MAX) ? lk_q : lk_q + LK_W'(1);
                if (lk_d == LK_MAX) begin
                    lock_d = 1'b1;
                end
            end else begin
                lk_d   = '0;
                lock_d = 1'b0;
            end
        end

        up_d = (state_d == ST_REF_LEAD);
        dn_d = (state_d == ST_FB_LEAD);
    end

    // Detector state and registered outputs
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            up_q        <= 1'b0;
            dn_q        <= 1'b0;
            phase_err_q <= '0;
            err_valid_q <= 1'b0;
            lk_q        <= '0;
            lock_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            up_q        <= up_d;
            dn_q        <= dn_d;
            phase_err_q <= phase_err_d;
            err_valid_q <= err_valid_d;
            lk_q        <= lk_d;
            lock_q      <= lock_d;
        end
    end

    assign up        = up_q;
    assign dn        = dn_q;
    assign phase_err = phase_err_q;
    assign err_valid = err_valid_q;
    assign lock      = lock_q;

endmodule

// File: tb/tb_phase_freq_detector.sv
// tb/tb_phase_freq_detector.sv - randomized and directed bench for phase_freq_detector

module tb_phase_freq_detector;

    localparam int S        = 2;
    localparam int LOCK_TOL = 2;
    localparam int LOCK_CNT = 8;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        ref_in;
    logic        fb_in;
    logic        up16, dn16, ev16, lock16;
    logic [15:0] pe16;
    logic        up4, dn4, ev4, lock4;
    logic [3:0]  pe4;

    int checks;
    int errors;

    phase_freq_detector #(.CNT_W(16), .SYNC_STAGES(S), .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT)) u_dut16 (
        .clk_in (clk), .rst_n (rst_n), .enable (enable), .ref_in (ref_in), .fb_in (fb_in),
        .up (up16), .dn (dn16), .phase_err (pe16), .err_valid (ev16), .lock (lock16)
    );

    phase_freq_detector #(.CNT_W(4), .SYNC_STAGES(S), .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT)) u_dut4 (
        .clk_in (clk), .rst_n (rst_n), .enable (enable), .ref_in (ref_in), .fb_in (fb_in),
        .up (up4), .dn (dn4), .phase_err (pe4), .err_valid (ev4), .lock (lock4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: timestamps of the leading edge, error = elapsed cycles (clamped)
    logic [S+1:0] rh, fh;
    bit           rr, fr;
    int           cyc;
    int           side    [2];
    int           open_at [2];
    int           m_err   [2];
    int           run     [2];
    bit           m_valid [2];
    bit           m_lock  [2];
    int           maxv    [2] = '{32767, 7};

    task automatic measure(input int k, input int v);
        int mag;
        mag        = (v < 0) ? -v : v;
        m_valid[k] = 1'b1;
        m_err[k]   = v;
        if (mag <= LOCK_TOL) begin
            run[k] = (run[k] < LOCK_CNT) ? run[k] + 1 : LOCK_CNT;
            if (run[k] >= LOCK_CNT) m_lock[k] = 1'b1;
        end else begin
            run[k]    = 0;
            m_lock[k] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rh = '0;
            fh = '0;
            for (int k = 0; k < 2; k++) begin
                side[k] = 0; open_at[k] = 0; m_err[k] = 0; run[k] = 0;
                m_valid[k] = 1'b0; m_lock[k] = 1'b0;
            end
        end else begin
            cyc = cyc + 1;
            rh  = {rh[S:0], ref_in};
            fh  = {fh[S:0], fb_in};
            rr  = rh[S] & ~rh[S+1];
            fr  = fh[S] & ~fh[S+1];
            for (int k = 0; k < 2; k++) begin
                int el;
                m_valid[k] = 1'b0;
                el = cyc - open_at[k];
                if (el > maxv[k]) el = maxv[k];
                if (!enable) begin
                    side[k] = 0; run[k] = 0; m_lock[k] = 1'b0;
                end else if (side[k] == 0) begin
                    if (rr && fr) measure(k, 0);
                    else if (rr) begin side[k] = 1;  open_at[k] = cyc; end
                    else if (fr) begin side[k] = -1; open_at[k] = cyc; end
                end else if (side[k] == 1) begin
                    if (fr) begin
                        measure(k, el);
                        if (rr) open_at[k] = cyc; else side[k] = 0;
                    end
                end else begin
                    if (rr) begin
                        measure(k, -el);
                        if (fr) open_at[k] = cyc; else side[k] = 0;
                    end
                end
            end
        end
    end

    int          n_up16, n_dn16, n_up4, n_ev;
    logic [15:0] ev_err[$];
    logic        ev_lock[$];
    logic [3:0]  ev_err4[$];
    logic        ev_lock4[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [15:0] e16;
        logic [3:0]  e4;
        e16 = 16'(m_err[0]);
        e4  = 4'(m_err[1]);
        chk("up16",   32'(up16),   32'(side[0] == 1));
        chk("dn16",   32'(dn16),   32'(side[0] == -1));
        chk("ev16",   32'(ev16),   32'(m_valid[0]));
        chk("pe16",   32'(pe16),   32'(e16));
        chk("lock16", 32'(lock16), 32'(m_lock[0]));
        chk("up4",    32'(up4),    32'(side[1] == 1));
        chk("dn4",    32'(dn4),    32'(side[1] == -1));
        chk("ev4",    32'(ev4),    32'(m_valid[1]));
        chk("pe4",    32'(pe4),    32'(e4));
        chk("lock4",  32'(lock4),  32'(m_lock[1]));
    endtask

    task automatic clear_stats();
        n_up16 = 0; n_dn16 = 0; n_up4 = 0; n_ev = 0;
        ev_err.delete(); ev_lock.delete(); ev_err4.delete(); ev_lock4.delete();
    endtask

    task automatic step(input logic r, input logic f, input logic e);
        @(posedge clk);
        #1;
        ref_in = r;
        fb_in  = f;
        enable = e;
        @(negedge clk);
        check_outputs();
        if (up16) n_up16++;
        if (dn16) n_dn16++;
        if (up4)  n_up4++;
        if (ev16) begin
            n_ev++;
            ev_err.push_back(pe16);
            ev_lock.push_back(lock16);
        end
        if (ev4) begin
            ev_err4.push_back(pe4);
            ev_lock4.push_back(lock4);
        end
    endtask

    // Two-cycle pulses on ref/fb at the given offsets, optional extra ref pulse, then quiet tail
    task automatic run_pair(input int rd, input int fd, input int xr);
        int hi;
        hi = rd;
        if (fd > hi) hi = fd;
        if (xr > hi) hi = xr;
        for (int c = 0; c < hi + 14; c++) begin
            logic r, f;
            r = ((c >= rd) && (c < rd + 2)) || ((xr >= 0) && (c >= xr) && (c < xr + 2));
            f = (c >= fd) && (c < fd + 2);
            step(r, f, 1'b1);
        end
    endtask

    initial begin
        logic [15:0] held;
        checks = 0; errors = 0; cyc = 0;
        enable = 1'b0; ref_in = 1'b0; fb_in = 1'b0;
        rst_n  = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_up",   32'(up16),   32'd0);
        chk("rst_dn",   32'(dn16),   32'd0);
        chk("rst_pe",   32'(pe16),   32'd0);
        chk("rst_ev",   32'(ev16),   32'd0);
        chk("rst_lock", 32'(lock16), 32'd0);
        check_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);

        // ref leads by 5
        clear_stats();
        run_pair(0, 5, -1);
        chk("lead5_up_cycles", 32'(n_up16), 32'd5);
        chk("lead5_dn_cycles", 32'(n_dn16), 32'd0);
        chk("lead5_ev_count",  32'(n_ev),   32'd1);
        chk("lead5_err",       32'(ev_err[0]), 32'd5);

        // fb leads by 3
        clear_stats();
        run_pair(3, 0, -1);
        chk("lag3_dn_cycles", 32'(n_dn16), 32'd3);
        chk("lag3_up_cycles", 32'(n_up16), 32'd0);
        chk("lag3_err",       32'(ev_err[0]), 32'h0000FFFD);

        // coincident edges
        clear_stats();
        run_pair(0, 0, -1);
        chk("same_up_cycles", 32'(n_up16 + n_dn16), 32'd0);
        chk("same_ev_count",  32'(n_ev), 32'd1);
        chk("same_err",       32'(ev_err[0]), 32'd0);

        // clear the run counter, then lock acquisition and loss
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        clear_stats();
        for (int i = 0; i < 10; i++) run_pair(0, 1, -1);
        chk("lock_ev_count", 32'(ev_lock.size()), 32'd10);
        chk("lock_at_7th",   32'(ev_lock[6]), 32'd0);
        chk("lock_at_8th",   32'(ev_lock[7]), 32'd1);
        chk("lock_at_10th",  32'(ev_lock[9]), 32'd1);
        clear_stats();
        run_pair(0, 7, -1);
        chk("unlock_err",  32'(ev_err[0]),  32'd7);
        chk("unlock_lock", 32'(ev_lock[0]), 32'd0);

        // relock, then saturate the 4-bit instance
        for (int i = 0; i < 8; i++) run_pair(0, 1, -1);
        chk("relock4", 32'(lock4), 32'd1);
        clear_stats();
        run_pair(0, 20, -1);
        chk("sat_up4_cycles", 32'(n_up4),       32'd20);
        chk("sat_err4",       32'(ev_err4[0]),  32'd7);
        chk("sat_lock4",      32'(ev_lock4[0]), 32'd0);
        chk("sat_err16",      32'(ev_err[0]),   32'd20);

        // enable dropped while ref leads
        held = pe16;
        clear_stats();
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("en_drop_up_before", 32'(up16), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("en_drop_up_after", 32'(up16), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
        chk("en_drop_no_ev", 32'(n_ev), 32'd0);
        chk("en_drop_held",  32'(pe16), 32'(held));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);

        // asynchronous reset mid-measurement
        clear_stats();
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("rst_mid_up_before", 32'(up16), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_up16", 32'(up16), 32'd0);
        chk("rst_mid_pe16", 32'(pe16), 32'd0);
        chk("rst_mid_up4",  32'(up4),  32'd0);
        check_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
        chk("rst_mid_no_ev", 32'(n_ev), 32'd0);

        // randomized edge timing, including extra ref edges (frequency error)
        for (int i = 0; i < 40; i++) begin
            int rd, fd, xr;
            rd = int'($urandom_range(0, 10));
            fd = int'($urandom_range(0, 10));
            xr = -1;
            if ($urandom_range(0, 3) == 0) xr = rd + 4 + int'($urandom_range(0, 4));
            run_pair(rd, fd, xr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
